dmem_responder: RTL and testbench

- Responder side of the MEM-stage data-memory interface. The pipeline initiates each access; this block serves it.
- Accepts one request at a time, with fields: read/write, size, sign-extend, address and write data.
- Stores data big-endian (SPARC ordering) in a byte-wide array. Moves one byte per cycle.
- Returns read data, with optional sign extension, under a one-cycle ack. Asserts busy so the hazard unit can stall the pipeline.

---
 rtl/dmem_responder_pkg.sv | 59 +++++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_byte_array.sv | 32 +++
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds size and state encodings, the request control payload, and helpers
// for transfer length, legality and read-data extension.
package dmem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    ERR    = 2'b11
  } state_e;

  // Control fields latched at accept
  typedef struct packed {
    logic  rw;
    size_e size;
    logic  se;
  } ctrl_t;

  // Number of bytes moved for a size code (0 for the illegal code)
  function automatic logic [2:0] nbytes(size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // True for any request that must be refused: bad alignment or the illegal size
  function automatic logic misaligned(size_e size, logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      SZ_WORD: return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Zero- or sign-extend an assembled byte/halfword; words pass through
  function automatic logic [WORD_W-1:0] extend(logic [WORD_W-1:0] v, size_e size, logic se);
    case (size)
      SZ_BYTE: return se ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
      SZ_HALF: return se ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the responder (slave).
// Request: req, rw, size, se, addr, wdata. Response: ack, busy, rdata, err.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
);
  logic              req;
  logic              rw;
  logic [1:0]        size;
  logic              se;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic              busy;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output req, rw, size, se, addr, wdata,
    input  ack, busy, rdata, err
  );

  modport slave (
    input  req, rw, size, se, addr, wdata,
    output ack, busy, rdata, err
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-wide storage, 2**ADDR_W entries, with LANES consecutive byte lanes
// starting at addr. Synchronous per-lane write, asynchronous read.
// Ports: clk; addr (lane-0 address); we/wd (per-lane write); rd (per-lane read).
// Storage is the unpacked array "mem" so a bench can inspect it directly.
module dmem_byte_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LANES  = 1
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [LANES-1:0]      we,
  input  logic [LANES-1:0][7:0] wd,
  output logic [LANES-1:0][7:0] rd
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // Contents survive reset by design
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (we[k]) mem[addr + ADDR_W'(k)] <= wd[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      rd[k] = mem[addr + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the MEM-stage data-memory interface.
// Serves one big-endian byte/halfword/word access at a time from a byte array,
// returning a one-cycle ack with read data (optionally sign-extended) or err.
// Ports: clk; clr (async, active-low reset); bus (dmem_responder_if.slave).
// Build option: DMEM_FAST_EN moves all bytes of an access in one edge and
// drops the byte counter; otherwise one byte moves per edge.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           clr,
  dmem_responder_if.slave bus
);
`ifdef DMEM_FAST_EN
  localparam int unsigned LANES = 4;
`else
  localparam int unsigned LANES = 1;
`endif

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] asm_step;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [2:0]        nb;
  logic              last;
  size_e             req_size;

  logic [ADDR_W-1:0]     arr_addr;
  logic [LANES-1:0]      arr_we;
  logic [LANES-1:0][7:0] arr_wd;
  logic [LANES-1:0][7:0] arr_rd;

`ifndef DMEM_FAST_EN
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
`endif

  assign req_size = size_e'(bus.size);
  assign nb       = nbytes(ctrl_q.size);

  dmem_byte_array #(
    .ADDR_W(ADDR_W),
    .LANES (LANES)
  ) u_array (
    .clk (clk),
    .addr(arr_addr),
    .we  (arr_we),
    .wd  (arr_wd),
    .rd  (arr_rd)
  );

`ifndef DMEM_FAST_EN
  // One lane: byte k sits at base+k and takes wdata byte (n-1-k), MSB first
  always_comb begin
    arr_addr = base_q + ADDR_W'(cnt_q);
    arr_we   = (state_q == ACCESS) && ctrl_q.rw;
    arr_wd   = 8'(wdata_q >> {2'(nb - 3'd1 - {1'b0, cnt_q}), 3'b000});
    asm_step = {asm_q[DATA_W-9:0], arr_rd[0]};
    last     = cnt_q == 2'(nb - 3'd1);
  end
`else
  // Four lanes: every byte of the access moves on the single ACCESS edge
  always_comb begin
    arr_addr = base_q;
    arr_we   = '0;
    arr_wd   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (3'(k) < nb) begin
        arr_we[k] = (state_q == ACCESS) && ctrl_q.rw;
        arr_wd[k] = 8'(wdata_q >> {2'(nb - 3'd1 - 3'(k)), 3'b000});
      end
    end
    case (ctrl_q.size)
      SZ_HALF: asm_step = {16'h0, arr_rd[0], arr_rd[1]};
      SZ_WORD: asm_step = {arr_rd[0], arr_rd[1], arr_rd[2], arr_rd[3]};
      default: asm_step = {24'h0, arr_rd[0]};
    endcase
    last = 1'b1;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifndef DMEM_FAST_EN
    cnt_d   = cnt_q;
    asm_d   = asm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          ctrl_d.rw   = bus.rw;
          ctrl_d.size = req_size;
          ctrl_d.se   = bus.se;
          base_d      = bus.addr;
          wdata_d     = bus.wdata;
          busy_d      = 1'b1;
`ifndef DMEM_FAST_EN
          cnt_d       = '0;
          asm_d       = '0;
`endif
          // Refused requests skip the array and report immediately
          if (misaligned(req_size, bus.addr[1:0])) begin
            state_d = ERR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
`ifndef DMEM_FAST_EN
        asm_d = asm_step;
        cnt_d = cnt_q + 2'd1;
`endif
        if (last) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = ctrl_q.rw ? '0 : extend(asm_step, ctrl_q.size, ctrl_q.se);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifndef DMEM_FAST_EN
      cnt_q   <= '0;
      asm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifndef DMEM_FAST_EN
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
`endif
    end
  end

  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed requests, a transaction-level memory model
// checked every cycle, and literal expectations for the documented scenarios.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(9)) bus();

  dmem_responder #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Edges are numbered by cyc; an access accepted at edge c acks at edge c+lat,
  // where lat = bytes moved (1 in fast mode) or 0 for a refused request,
  // and the next request can be taken two edges after the ack edge.
  typedef struct {
    int         edge_no;
    int         a;
    logic [7:0] d;
  } wr_t;

  logic [7:0]  mem_m [512];
  wr_t         pend[$];
  int          cyc       = 0;
  int          acc_edge  = -10;
  int          ack_edge  = -20;
  int          free_edge = 0;
  bit          m_ill     = 1'b0;
  logic [31:0] m_rdata   = '0;
  logic [31:0] m_rnext   = '0;
  int          mn, ma;
  longint unsigned mv;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend.delete();
      acc_edge  = -10;
      ack_edge  = -20;
      free_edge = 0;
      m_ill     = 1'b0;
      m_rdata   = '0;
    end else begin
      cyc++;
      foreach (pend[i]) if (pend[i].edge_no == cyc) mem_m[pend[i].a] = pend[i].d;
      if (bus.req && cyc >= free_edge) begin
        mn = (bus.size == 2'd0) ? 1 : (bus.size == 2'd1) ? 2 : (bus.size == 2'd2) ? 4 : 0;
        ma = int'(bus.addr);
        m_ill = (mn == 0) || ((ma % mn) != 0);
        acc_edge = cyc;
        if (m_ill) begin
          ack_edge = cyc;
          m_rnext  = '0;
        end else begin
`ifdef DMEM_FAST_EN
          ack_edge = cyc + 1;
`else
          ack_edge = cyc + mn;
`endif
          if (bus.rw) begin
            for (int k = 0; k < mn; k++) begin
`ifdef DMEM_FAST_EN
              pend.push_back('{cyc + 1, ma + k, 8'(bus.wdata >> (8 * (mn - 1 - k))) });
`else
              pend.push_back('{cyc + 1 + k, ma + k, 8'(bus.wdata >> (8 * (mn - 1 - k))) });
`endif
            end
            m_rnext = '0;
          end else begin
            mv = 0;
            for (int k = 0; k < mn; k++) mv = mv * 256 + longint'(mem_m[ma + k]);
            if (bus.se && mn < 4 && mv >= (64'd1 << (8 * mn - 1)))
              mv = mv + 64'h1_0000_0000 - (64'd1 << (8 * mn));
            m_rnext = 32'(mv);
          end
        end
        free_edge = ack_edge + 2;
      end
      if (cyc == ack_edge) m_rdata = m_rnext;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("ack",   32'(bus.ack),   32'(cyc == ack_edge));
      chk("busy",  32'(bus.busy),  32'(cyc >= acc_edge && cyc <= ack_edge));
      chk("err",   32'(bus.err),   32'(cyc == ack_edge && m_ill));
      chk("rdata", bus.rdata,      m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit rw, input logic [1:0] sz, input bit se,
                       input logic [8:0] a, input logic [31:0] wd);
    bus.req = 1'b1; bus.rw = rw; bus.size = sz; bus.se = se; bus.addr = a; bus.wdata = wd;
  endtask

  // After acceptance the request fields are irrelevant, so fill them with noise
  task automatic scramble();
    bus.req   = 1'b0;
    bus.rw    = 1'($urandom);
    bus.size  = 2'($urandom);
    bus.se    = 1'($urandom);
    bus.addr  = 9'($urandom);
    bus.wdata = $urandom;
  endtask

  // One request; lat = edges from the accept edge to the edge raising ack
  task automatic xact(input bit rw, input logic [1:0] sz, input bit se,
                      input logic [8:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    drive(rw, sz, se, a, wd);
    @(negedge clk);
    scramble();
    lat = 0;
    while (!bus.ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.ack) chk("ack_timeout", 32'(bus.ack), 32'd1);
    rd = bus.rdata;
    er = bus.err;
  endtask

  task automatic chk_mem(input string name, input int a, input logic [7:0] exp);
    chk(name, 32'(dut.u_array.mem[a]), 32'(exp));
  endtask

  task automatic chk_model_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) chk("mem_vs_model", 32'(dut.u_array.mem[a]), 32'(mem_m[a]));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          lat_b, lat_h, lat_w;
  int          first_ack, second_ack, low_cycles, got, k;
  logic [31:0] r1, r2;

  initial begin
`ifdef DMEM_FAST_EN
    lat_b = 1; lat_h = 1; lat_w = 1;
`else
    lat_b = 1; lat_h = 2; lat_w = 4;
`endif
    bus.req = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.se = 1'b0;
    bus.addr = '0; bus.wdata = '0;

    // Reset
    #3 clr = 1'b0;
    #1 check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ack",   32'(bus.ack),  32'd0);
    chk("reset_busy",  32'(bus.busy), 32'd0);
    chk("reset_rdata", bus.rdata,     32'd0);
    chk("reset_err",   32'(bus.err),  32'd0);
    clr = 1'b1;

    // Known prior contents at 0x22/0x23 for the reset-abort scenario
    xact(1'b1, 2'b00, 1'b0, 9'h022, 32'h0000_0055, rd, er, lat);
    chk("pre_lat", 32'(lat), 32'(lat_b));
    xact(1'b1, 2'b00, 1'b0, 9'h023, 32'h0000_0066, rd, er, lat);

    // 1: word write, big-endian
    xact(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, rd, er, lat);
    chk("w_word_lat",   32'(lat), 32'(lat_w));
    chk("w_word_err",   32'(er),  32'd0);
    chk("w_word_rdata", rd,       32'd0);
    chk_mem("w_word_b0", 'h10, 8'hDE);
    chk_mem("w_word_b1", 'h11, 8'hAD);
    chk_mem("w_word_b2", 'h12, 8'hBE);
    chk_mem("w_word_b3", 'h13, 8'hEF);

    // 2: byte reads with and without sign extension
    xact(1'b0, 2'b00, 1'b1, 9'h011, 32'h0, rd, er, lat);
    chk("r_byte_se",     rd,       32'hFFFF_FFAD);
    chk("r_byte_se_lat", 32'(lat), 32'(lat_b));
    xact(1'b0, 2'b00, 1'b0, 9'h011, 32'h0, rd, er, lat);
    chk("r_byte_ze",     rd,       32'h0000_00AD);

    // 3: halfword reads
    xact(1'b0, 2'b01, 1'b1, 9'h012, 32'h0, rd, er, lat);
    chk("r_half_se",     rd,       32'hFFFF_BEEF);
    chk("r_half_se_lat", 32'(lat), 32'(lat_h));
    xact(1'b0, 2'b01, 1'b0, 9'h012, 32'h0, rd, er, lat);
    chk("r_half_ze",     rd,       32'h0000_BEEF);
    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, rd, er, lat);
    chk("r_word",        rd,       32'hDEAD_BEEF);

    // 4: refused requests report in the cycle right after acceptance
    xact(1'b0, 2'b10, 1'b0, 9'h012, 32'h0, rd, er, lat);
    chk("ill_word_err",   32'(er),  32'd1);
    chk("ill_word_rdata", rd,       32'd0);
    chk("ill_word_lat",   32'(lat), 32'd0);
    xact(1'b1, 2'b11, 1'b0, 9'h000, 32'h1234_5678, rd, er, lat);
    chk("ill_size_err",   32'(er),  32'd1);
    chk("ill_size_lat",   32'(lat), 32'd0);
    xact(1'b1, 2'b01, 1'b0, 9'h011, 32'h0000_9999, rd, er, lat);
    chk("ill_half_err",   32'(er),  32'd1);
    chk_mem("ill_keep_b1", 'h11, 8'hAD);
    chk_mem("ill_keep_b2", 'h12, 8'hBE);
    chk_model_mem('h10, 'h13);

    // 5: reset two edges into a word write
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 9'h020, 32'h1122_3344);
    @(posedge clk);
    @(negedge clk);
    scramble();
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_ack",   32'(bus.ack),  32'd0);
    chk("abort_rdata", bus.rdata,     32'd0);
    chk_mem("abort_b0", 'h20, 8'h11);
    chk_mem("abort_b1", 'h21, 8'h22);
`ifdef DMEM_FAST_EN
    chk_mem("abort_b2", 'h22, 8'h33);
    chk_mem("abort_b3", 'h23, 8'h44);
`else
    chk_mem("abort_b2", 'h22, 8'h55);
    chk_mem("abort_b3", 'h23, 8'h66);
`endif
    chk_model_mem('h20, 'h23);
    @(negedge clk);
    clr = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, rd, er, lat);
`ifdef DMEM_FAST_EN
    chk("post_abort_word", rd, 32'h1122_3344);
`else
    chk("post_abort_word", rd, 32'h1122_5566);
`endif
    chk("post_abort_lat", 32'(lat), 32'(lat_w));

    // 6: req held high for two byte reads; ack, idle, access, ack
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
    first_ack = -1; second_ack = -1; low_cycles = 0; got = 0; k = 0;
    r1 = '0; r2 = '0;
    while (got < 2 && k < 40) begin
      @(negedge clk);
      k++;
      if (got == 0) bus.addr = 9'h013;
      if (bus.ack) begin
        if (got == 0) begin first_ack = k; r1 = bus.rdata; end
        else begin second_ack = k; r2 = bus.rdata; end
        got++;
      end else if (got == 1 && !bus.busy) begin
        low_cycles++;
      end else if (got == 1 && bus.busy && low_cycles > 0) begin
        bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    chk("b2b_acks_seen", 32'(got),                    32'd2);
    chk("b2b_rdata0",    r1,                          32'h0000_00DE);
    chk("b2b_rdata1",    r2,                          32'h0000_00EF);
    chk("b2b_spacing",   32'(second_ack - first_ack), 32'd3);
    chk("b2b_idle",      32'(low_cycles),             32'd1);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
